step_sequencer: RTL and testbench

- Control FSM that sequences an iterative datapath, such as a serial shift/accumulate unit, through a fixed number of steps.
- Uses an internal modulo step counter with first-step and last-step flags of the same kind as the team's existing counter blocks.
- Sits between the upstream requester (start/ready handshake) and the datapath it drives (load_en, step_en, step_index).
- Holds completion (done) until the consumer acknowledges it.

---
 rtl/step_sequencer_if.sv | 38 +++
 rtl/step_sequencer.sv | 100 ++++++++++
 tb/tb_step_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_if.sv
// Handshake and datapath-control bundle between a requester, the step sequencer and its datapath.
// Carries the abort request only when STEP_SEQUENCER_ABORT_EN is defined.
interface step_sequencer_if #(
    parameter int unsigned NBITS = 5
);
`ifdef STEP_SEQUENCER_ABORT_EN
    logic             abort;
`endif
    logic             start;
    logic             hold;
    logic             done_ack;
    logic             ready;
    logic             busy;
    logic             load_en;
    logic             step_en;
    logic [NBITS-1:0] step_index;
    logic             first_step;
    logic             last_step;
    logic             done;

    // Requester/consumer side
    modport master (
`ifdef STEP_SEQUENCER_ABORT_EN
        output abort,
`endif
        output start, hold, done_ack,
        input  ready, busy, load_en, step_en, step_index, first_step, last_step, done
    );

    // Sequencer side
    modport slave (
`ifdef STEP_SEQUENCER_ABORT_EN
        input  abort,
`endif
        input  start, hold, done_ack,
        output ready, busy, load_en, step_en, step_index, first_step, last_step, done
    );
endinterface

// File: rtl/step_sequencer.sv
// IDLE/LOAD/RUN/DONE control FSM stepping a datapath NUM_STEPS times per operation.
// Optional STEP_SEQUENCER_ABORT_EN adds an abort input that cancels LOAD/RUN back to IDLE.
module step_sequencer #(
    parameter int unsigned NUM_STEPS       = 32,
    parameter int unsigned NBITS_FOR_STEPS = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    step_sequencer_if.slave  bus
);
    if (NUM_STEPS < 2) begin : g_bad_num_steps
        $error("step_sequencer: NUM_STEPS must be at least 2");
    end

    localparam logic [NBITS_FOR_STEPS-1:0] LAST_STEP = NBITS_FOR_STEPS'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                     state, state_n;
    logic [NBITS_FOR_STEPS-1:0] count, count_n;
    logic                       step_en_c;
    logic                       abort_c;
    logic                       ready_q, busy_q, load_en_q, first_q, last_q, done_q;

`ifdef STEP_SEQUENCER_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    // Next state, next count and the combinational step strobe
    always_comb begin
        state_n   = state;
        count_n   = count;
        step_en_c = 1'b0;
        case (state)
            IDLE: if (bus.start) state_n = LOAD;
            LOAD: begin
                count_n = '0;
                state_n = RUN;
            end
            RUN: begin
                step_en_c = ~bus.hold;
                if (step_en_c) begin
                    // Explicit wrap compare, even when NUM_STEPS is a power of two
                    if (count == LAST_STEP) begin
                        count_n = '0;
                        state_n = DONE;
                    end else begin
                        count_n = count + NBITS_FOR_STEPS'(1);
                    end
                end
            end
            DONE: if (bus.done_ack) state_n = IDLE;
        endcase
        // Abort outranks both hold and the last-step transition
        if (abort_c && (state == LOAD || state == RUN)) begin
            state_n   = IDLE;
            count_n   = '0;
            step_en_c = 1'b0;
        end
    end

    // State, counter and Moore flags registered from the next-state decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            load_en_q <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            ready_q   <= (state_n == IDLE);
            busy_q    <= (state_n == LOAD) || (state_n == RUN);
            load_en_q <= (state_n == LOAD);
            first_q   <= (state_n == RUN) && (count_n == '0);
            last_q    <= (state_n == RUN) && (count_n == LAST_STEP);
            done_q    <= (state_n == DONE);
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.load_en    = load_en_q;
    assign bus.step_en    = step_en_c;
    assign bus.step_index = count;
    assign bus.first_step = first_q;
    assign bus.last_step  = last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer (NUM_STEPS = 32) with an independent step/latency model.
module tb_step_sequencer;
    localparam int unsigned NUM_STEPS = 32;
    localparam int unsigned NB        = 5;

    // {ready, busy, load_en, step_en, first_step, last_step, done}
    localparam logic [6:0] IDLE_P = 7'b1000000;
    localparam logic [6:0] LOAD_P = 7'b0110000;
    localparam logic [6:0] DONE_P = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    step_sequencer_if #(.NBITS(NB)) bus ();

    step_sequencer #(.NUM_STEPS(NUM_STEPS), .NBITS_FOR_STEPS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [6:0] outs();
        return {bus.ready, bus.busy, bus.load_en, bus.step_en,
                bus.first_step, bus.last_step, bus.done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from IDLE (called just after a negedge) and follow it to DONE.
    // Hold is raised for hla cycles at step ha and hlb cycles at step hb.
    task automatic run_op(input int ha, input int hla, input int hb, input int hlb,
                          input int exp_edges);
        int   edges, steps, exp_idx, ra, rb;
        bit   in_run, seen_done;
        logic h;
        edges = 0; steps = 0; exp_idx = 0; ra = hla; rb = hlb;
        in_run = 1'b1; seen_done = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("load_cycle", 32'(outs()), 32'(LOAD_P));
        for (int i = 0; i < 200 && !seen_done; i++) begin
            @(posedge clk); #1;
            edges++;
            if (in_run) begin
                h = 1'b0;
                if (exp_idx == ha && ra > 0) begin
                    h = 1'b1; ra--;
                end else if (exp_idx == hb && rb > 0) begin
                    h = 1'b1; rb--;
                end
                bus.hold = h;
                @(negedge clk);
                check("run_index", 32'(bus.step_index), 32'(exp_idx));
                check("run_flags", 32'(outs()),
                      32'({1'b0, 1'b1, 1'b0, ~h, exp_idx == 0,
                           exp_idx == int'(NUM_STEPS) - 1, 1'b0}));
                if (!h) begin
                    steps++;
                    if (exp_idx == int'(NUM_STEPS) - 1) begin
                        in_run  = 1'b0;
                        exp_idx = 0;
                    end else begin
                        exp_idx++;
                    end
                end
            end else begin
                bus.hold = 1'b0;
                @(negedge clk);
                check("done_flags", 32'(outs()), 32'(DONE_P));
                check("done_index", 32'(bus.step_index), 32'd0);
                check("done_latency", 32'(edges), 32'(exp_edges));
                seen_done = 1'b1;
            end
        end
        check("op_completed", 32'(seen_done), 32'd1);
        check("step_count", 32'(steps), 32'(NUM_STEPS));
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.hold     = 1'b0;
        bus.done_ack = 1'b0;
`ifdef STEP_SEQUENCER_ABORT_EN
        bus.abort    = 1'b0;
`endif
        // Reset and quiet idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_flags", 32'(outs()), 32'(IDLE_P));
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_flags", 32'(outs()), 32'(IDLE_P));
            check("idle_index", 32'(bus.step_index), 32'd0);
        end

        // Plain operation, done_ack tied high: DONE lasts one cycle
        bus.done_ack = 1'b1;
        run_op(-1, 0, -1, 0, 33);
        @(negedge clk);
        check("after_ack_idle", 32'(outs()), 32'(IDLE_P));

        // Hold 3 cycles at step 10 and 2 cycles at step 31: five extra cycles
        run_op(10, 3, 31, 2, 38);
        @(negedge clk);
        check("after_hold_idle", 32'(outs()), 32'(IDLE_P));

        // done held 7 cycles; start during DONE and together with done_ack is ignored
        bus.done_ack = 1'b0;
        run_op(-1, 0, -1, 0, 33);
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            bus.start    = (k == 3) || (k == 7);
            bus.done_ack = (k == 7);
            @(negedge clk);
            check("done_held", 32'(outs()), 32'(DONE_P));
        end
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.done_ack = 1'b1;
        @(negedge clk);
        check("ack_to_idle", 32'(outs()), 32'(IDLE_P));
        @(negedge clk);
        check("no_second_load", 32'(outs()), 32'(IDLE_P));

        // Asynchronous reset at step 17, then a clean full operation
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("pre_reset_index", 32'(bus.step_index), 32'd17);
        #2 reset = 1'b1;
        #1;
        check("async_reset_flags", 32'(outs()), 32'(IDLE_P));
        check("async_reset_index", 32'(bus.step_index), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(outs()), 32'(IDLE_P));
        run_op(-1, 0, -1, 0, 33);
        @(negedge clk);
        check("post_reset_op_idle", 32'(outs()), 32'(IDLE_P));

`ifdef STEP_SEQUENCER_ABORT_EN
        // Abort on the last step with hold high: straight back to IDLE, no done
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        bus.hold  = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_cycle_index", 32'(bus.step_index), 32'd31);
        check("abort_cycle_flags", 32'(outs()), 32'(7'b0100010));
        @(posedge clk); #1;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_idle_flags", 32'(outs()), 32'(IDLE_P));
        check("abort_idle_index", 32'(bus.step_index), 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(outs()), 32'(IDLE_P));
        run_op(-1, 0, -1, 0, 33);
        @(negedge clk);
        check("post_abort_idle", 32'(outs()), 32'(IDLE_P));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
